// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave exposing REG_N read/write registers, with a per-register write pulse.
// The write and read channels each run their own two-state FSM and are fully independent.
module axi4_lite_reg_slave #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_N  = 8
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [ADDR_W-1:0]       AWADDR,
   input  logic [2:0]              AWPROT,
   input  logic                    WVALID,
   output logic                    WREADY,
   input  logic [DATA_W-1:0]       WDATA,
   input  logic [DATA_W/8-1:0]     WSTRB,
   output logic                    BVALID,
   input  logic                    BREADY,
   output logic [1:0]              BRESP,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   input  logic [ADDR_W-1:0]       ARADDR,
   input  logic [2:0]              ARPROT,
   output logic                    RVALID,
   input  logic                    RREADY,
   output logic [DATA_W-1:0]       RDATA,
   output logic [1:0]              RRESP,
   output logic [REG_N*DATA_W-1:0] reg_q,
   output logic [REG_N-1:0]        wr_pulse
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [0:0] W_IDLE = 1'b0;
   localparam logic [0:0] W_RESP = 1'b1;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_RESP = 1'b1;

   // Register file
   logic [DATA_W-1:0] regs_q [REG_N];
   logic [DATA_W-1:0] regs_d [REG_N];

   // Write path state
   logic [0:0]        w_state_q, w_state_d;
   logic              aw_got_q, aw_got_d;
   logic              w_got_q, w_got_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic              awready_q, awready_d;
   logic              wready_q, wready_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic [REG_N-1:0]  wr_pulse_q, wr_pulse_d;

   // Read path state
   logic [0:0]        r_state_q, r_state_d;
   logic              arready_q, arready_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;

   // Helper nets
   logic              aw_hs, w_hs, ar_hs;
   logic [ADDR_W-1:0] cm_addr, cm_idx, rd_idx;
   logic [DATA_W-1:0] cm_data;
   logic [STRB_W-1:0] cm_strb;

   // Protection bits carry no meaning for this slave
   logic unused_prot;
   assign unused_prot = ^{AWPROT, ARPROT};

   // Write FSM: capture AW and W in any order, commit on the second handshake, then respond
   always_comb begin
      w_state_d  = w_state_q;
      aw_got_d   = aw_got_q;
      w_got_d    = w_got_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      awready_d  = awready_q;
      wready_d   = wready_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wr_pulse_d = '0;
      regs_d     = regs_q;

      aw_hs   = AWVALID & awready_q;
      w_hs    = WVALID & wready_q;
      cm_addr = aw_got_q ? awaddr_q : AWADDR;
      cm_data = w_got_q ? wdata_q : WDATA;
      cm_strb = w_got_q ? wstrb_q : WSTRB;
      cm_idx  = cm_addr >> OFF_W;

      case (w_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               aw_got_d = 1'b1;
               awaddr_d = AWADDR;
            end
            if (w_hs) begin
               w_got_d = 1'b1;
               wdata_d = WDATA;
               wstrb_d = WSTRB;
            end
            if ((aw_got_q | aw_hs) && (w_got_q | w_hs)) begin
               w_state_d = W_RESP;
               aw_got_d  = 1'b0;
               w_got_d   = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b0;
               bvalid_d  = 1'b1;
               if (cm_idx < ADDR_W'(REG_N)) begin
                  bresp_d = RESP_OKAY;
                  for (int unsigned k = 0; k < REG_N; k++) begin
                     if (cm_idx == ADDR_W'(k)) begin
                        wr_pulse_d[k] = 1'b1;
                        for (int unsigned b = 0; b < STRB_W; b++) begin
                           if (cm_strb[b]) regs_d[k][b*8 +: 8] = cm_data[b*8 +: 8];
                        end
                     end
                  end
               end else begin
                  bresp_d = RESP_SLVERR;
               end
            end else begin
               awready_d = ~aw_got_d;
               wready_d  = ~w_got_d;
            end
         end
         W_RESP: begin
            if (BREADY) begin
               w_state_d = W_IDLE;
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read FSM: sample the pre-write register value on the AR handshake, hold until R handshake
   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;

      ar_hs  = ARVALID & arready_q;
      rd_idx = ARADDR >> OFF_W;

      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_d = R_RESP;
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               rdata_d   = '0;
               rresp_d   = RESP_SLVERR;
               if (rd_idx < ADDR_W'(REG_N)) begin
                  rresp_d = RESP_OKAY;
                  for (int unsigned k = 0; k < REG_N; k++) begin
                     if (rd_idx == ADDR_W'(k)) rdata_d = regs_q[k];
                  end
               end
            end else begin
               arready_d = 1'b1;
            end
         end
         R_RESP: begin
            if (RREADY) begin
               r_state_d = R_IDLE;
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // State registers; reset clears everything including partially captured AW/W
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         regs_q     <= '{default: '0};
         w_state_q  <= W_IDLE;
         aw_got_q   <= 1'b0;
         w_got_q    <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= 2'b00;
         wr_pulse_q <= '0;
         r_state_q  <= R_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= 2'b00;
      end else begin
         regs_q     <= regs_d;
         w_state_q  <= w_state_d;
         aw_got_q   <= aw_got_d;
         w_got_q    <= w_got_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         wr_pulse_q <= wr_pulse_d;
         r_state_q  <= r_state_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   // Flatten the register file onto the reg_q bus
   for (genvar g = 0; g < REG_N; g++) begin : g_flat
      assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign AWREADY  = awready_q;
   assign WREADY   = wready_q;
   assign BVALID   = bvalid_q;
   assign BRESP    = bresp_q;
   assign ARREADY  = arready_q;
   assign RVALID   = rvalid_q;
   assign RDATA    = rdata_q;
   assign RRESP    = rresp_q;
   assign wr_pulse = wr_pulse_q;

endmodule

// File: doc/axi4_lite_reg_slave.md
AXI4_LITE_REG_SLAVE -- requirements
Module: axi4_lite_reg_slave

Interface
REQ-001 Parameter ADDR_W, default 32: AXI address width.
REQ-002 Parameter DATA_W, default 32: data width; SHALL be 32 or 64.
REQ-003 Parameter REG_N, default 8: number of registers, 1..256.
REQ-004 ACLK  in  1  single clock; all logic on the rising edge.
REQ-005 ARESET  in  1  asynchronous, active-high reset.
REQ-006 AWVALID/AWREADY/AWADDR/AWPROT  in/out/in/in  1/1/ADDR_W/3  write address channel; AWPROT ignored.
REQ-007 WVALID/WREADY/WDATA/WSTRB  in/out/in/in  1/1/DATA_W/DATA_W/8  write data channel.
REQ-008 BVALID/BREADY/BRESP  out/in/out  1/1/2  write response channel.
REQ-009 ARVALID/ARREADY/ARADDR/ARPROT  in/out/in/in  1/1/ADDR_W/3  read address channel; ARPROT ignored.
REQ-010 RVALID/RREADY/RDATA/RRESP  out/in/out/out  1/1/DATA_W/2  read data channel.
REQ-011 reg_q  out  REG_N*DATA_W  current register contents; register k is at bits [k*DATA_W +: DATA_W].
REQ-012 wr_pulse  out  REG_N  bit k is high for one cycle after register k is written.

Function
REQ-013 Decode: word index = ADDR >> log2(DATA_W/8); index < REG_N is valid. Low byte-offset bits and the upper bits that select the index are ignored only as stated here.
REQ-014 Write FSM states: W_IDLE, W_RESP.
- In W_IDLE, AWREADY=1 until AW is captured and WREADY=1 until W is captured.
- AW and W are accepted in either order or in the same cycle.
REQ-015 A write commits on the clock edge that completes the second of the AW/W handshakes.
- Each byte lane i with WSTRB[i]=1 is updated; other lanes keep their value.
- The FSM then enters W_RESP.
REQ-016 In W_RESP: BVALID=1, AWREADY=0, WREADY=0.
- BRESP=2'b00 (OKAY) for a valid index; 2'b10 (SLVERR) for an invalid index, and no register changes.
REQ-017 BVALID and BRESP stay stable until BVALID&BREADY. The FSM then returns to W_IDLE on the next edge.
REQ-018 wr_pulse[k]=1 in the first W_RESP cycle of a valid write to k, including a write with WSTRB=0. Otherwise it is 0.
REQ-019 Read FSM states: R_IDLE (ARREADY=1), R_RESP (RVALID=1, ARREADY=0).
REQ-020 On the AR handshake edge, RDATA and RRESP are registered from the values present before any write committing on that same edge.
- Valid index: register value with RRESP=2'b00.
- Invalid index: zero with RRESP=2'b10.
REQ-021 RDATA and RRESP stay stable until RVALID&RREADY. The FSM then returns to R_IDLE.
REQ-022 Read and write paths are independent; a read can be accepted while a write response is pending and vice versa.
REQ-023 Latency: a read with RREADY=1 returns RVALID one cycle after the AR handshake. A write with BREADY=1 returns BVALID one cycle after commit. Peak throughput is one transaction per 2 cycles per channel.
REQ-024 VALID inputs asserted without READY are held off. The block never drops a handshake.

Reset
REQ-025 While ARESET=1, the following are 0:
- all registers (reg_q)
- AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, wr_pulse
- captured AW/W state.
REQ-026 Ready outputs are registered. AWREADY, WREADY and ARREADY become 1 in the first cycle after ARESET falls.
REQ-027 Reset asserted mid-transaction aborts it; a partially captured AW or W is discarded.

Verification
REQ-028 AW 0x04 and W 0xDEADBEEF with WSTRB=4'hF in the same cycle, BREADY=1 -> next cycle BVALID=1, BRESP=00, wr_pulse=8'h02, reg_q[63:32]=0xDEADBEEF.
REQ-029 W (0x11223344, WSTRB=4'b0101) three cycles before AW 0x08, reg2 initially 0xAABBCCDD -> AWREADY stays high and WREADY is low after W is taken; reg2=0xAA22CC44 after AW.
REQ-030 AR 0x20 with REG_N=8 -> RVALID with RDATA=0, RRESP=10. A write to 0x20 -> BRESP=10, reg_q unchanged, wr_pulse=0.
REQ-031 RREADY=0 for 5 cycles after RVALID -> RDATA and RVALID stable, ARREADY=0 throughout; a write to the same register during the stall does not alter the pending RDATA.
REQ-032 AR 0x00 handshake on the same edge as a write commit of 0x5 to reg0, which held 0x1 -> RDATA=0x1; a following read returns 0x5.
REQ-033 ARESET pulsed while BVALID=1 and BREADY=0 -> BVALID=0 and all reg_q=0 immediately; the ready outputs return to 1 in the first cycle after release.
